dmem_req_issue: RTL and testbench

Parametrised data-memory request issue unit for the EXE/MEM boundary of the pipelined CPU. It accepts one load/store per handshake, detects misalignment, and drives an SRAM-like req/addr_ok/data_ok bus with up to MAX_OUTSTANDING requests in flight. Returned load data is aligned and extended in order. A pipeline flush discards in-flight responses without stalling the bus.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_trk_fifo.sv | 44 ++++
 rtl/dmem_req_issue.sv | 106 ++++++++++
 tb/tb_dmem_req_issue.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: size codes, tracker entry layout and byte-lane helpers shared by the issue unit.
package dmem_pkg;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} sz_e;
  typedef struct packed {
    logic       ld;
    logic       se;
    sz_e        size;
    logic [2:0] off;
  } trk_t;
  function automatic logic misaligned(input sz_e sz, input logic [2:0] a);
    return sz == SZ_H ? a[0] : sz == SZ_W ? |a[1:0] : sz == SZ_D ? |a : 1'b0;
  endfunction
  // Helpers work on the 64-bit superset; callers truncate to DATA_W.
  function automatic logic [7:0] strobe(input sz_e sz, input logic [2:0] off);
    logic [7:0] m;
    m = sz == SZ_B ? 8'h01 : sz == SZ_H ? 8'h03 : sz == SZ_W ? 8'h0F : 8'hFF;
    return m << off;
  endfunction
  function automatic logic [63:0] replicate(input sz_e sz, input logic [63:0] d);
    return sz == SZ_B ? {8{d[7:0]}} : sz == SZ_H ? {4{d[15:0]}} : sz == SZ_W ? {2{d[31:0]}} : d;
  endfunction
  function automatic logic [63:0] extend(input sz_e sz, input logic se, input logic [63:0] r);
    return sz == SZ_B ? {{56{se & r[7]}}, r[7:0]} :
           sz == SZ_H ? {{48{se & r[15]}}, r[15:0]} :
           sz == SZ_W ? {{32{se & r[31]}}, r[31:0]} : r;
  endfunction
endpackage

// File: rtl/dmem_trk_fifo.sv
// dmem_trk_fifo: in-order tracker of issued requests with occupancy count and broadcast discard.
module dmem_trk_fifo #(
  parameter int W = 12,
  parameter int DEPTH = 4,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  input  logic          discard_all,
  output logic [W-1:0]  dout,
  output logic          dout_discard,
  output logic [CW-1:0] count
);
  logic [W-1:0]     r_mem [DEPTH];
  logic [DEPTH-1:0] r_disc;
  logic [PW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_disc <= '0;
    end else begin
      if (push) r_wp <= nxt(r_wp);
      if (pop) r_rp <= nxt(r_rp);
      r_cnt <= r_cnt + CW'(push) - CW'(pop);
      if (discard_all) r_disc <= '1;
      if (push) r_disc[r_wp] <= discard_all;
    end
  end
  always_ff @(posedge clk)
    if (push) r_mem[r_wp] <= din;
  assign dout         = r_mem[r_rp];
  assign dout_discard = r_disc[r_rp];
  assign count        = r_cnt;
endmodule

// File: rtl/dmem_req_issue.sv
// dmem_req_issue: one-entry hold register issuing loads/stores onto an SRAM-like bus,
// tracking outstanding requests and returning aligned, extended load data in order.
module dmem_req_issue
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RD_W = 5
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_ld,
  input  logic                in_st,
  input  logic [1:0]          in_size,
  input  logic                in_se,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [RD_W-1:0]     in_rd,
  input  logic                flush,
  output logic                req,
  output logic                wr,
  output logic [1:0]          size,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  input  logic                addr_ok,
  input  logic                data_ok,
  input  logic [DATA_W-1:0]   rdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [RD_W-1:0]     rsp_rd,
  output logic                exc_ale,
  output logic [ADDR_W-1:0]   exc_badv
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int TW = $bits(trk_t) + RD_W;
  logic              r_hv, r_ld, r_st, r_se, r_ale;
  sz_e               r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [RD_W-1:0]   r_rd;
  logic              w_leave, w_accept, w_push, w_pop, w_disc;
  logic [2:0]        w_off;
  logic [CW-1:0]     w_cnt;
  logic [TW-1:0]     w_dout;
  trk_t              w_new, w_trk;
  logic [RD_W-1:0]   w_rd;
  assign w_leave  = (req & addr_ok) | exc_ale;
  assign in_ready = ~flush & (~r_hv | w_leave);
  assign w_accept = in_valid & in_ready;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_hv    <= 1'b0;
      r_ld    <= 1'b0;
      r_st    <= 1'b0;
      r_se    <= 1'b0;
      r_ale   <= 1'b0;
      r_size  <= SZ_B;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
    end else if (flush) begin
      r_hv <= 1'b0;
    end else if (w_accept) begin
      r_hv    <= 1'b1;
      r_ld    <= in_ld;
      r_st    <= in_st;
      r_se    <= in_se;
      r_ale   <= misaligned(sz_e'(in_size), in_addr[2:0]);
      r_size  <= sz_e'(in_size);
      r_addr  <= in_addr;
      r_wdata <= in_wdata;
      r_rd    <= in_rd;
    end else if (w_leave) begin
      r_hv <= 1'b0;
    end
  end
  // Bus outputs come straight from the hold register so they stay put until addr_ok.
  assign w_off    = 3'(r_addr[OW-1:0]);
  assign req      = r_hv & ~r_ale & (w_cnt < CW'(MAX_OUTSTANDING)) & ~flush;
  assign wr       = r_st;
  assign size     = r_size;
  assign addr     = r_addr;
  assign wstrb    = r_st ? NB'(strobe(r_size, w_off)) : '0;
  assign wdata    = DATA_W'(replicate(r_size, 64'(r_wdata)));
  assign exc_ale  = r_hv & r_ale & ~flush;
  assign exc_badv = exc_ale ? r_addr : '0;
  assign w_new    = '{ld: r_ld, se: r_se, size: r_size, off: w_off};
  assign w_push   = req & addr_ok;
  assign w_pop    = data_ok & (w_cnt != '0);
  dmem_trk_fifo #(.W(TW), .DEPTH(MAX_OUTSTANDING)) u_trk (
    .clk(clk), .resetn(resetn), .push(w_push), .din({w_new, r_rd}), .pop(w_pop),
    .discard_all(flush), .dout(w_dout), .dout_discard(w_disc), .count(w_cnt)
  );
  assign {w_trk, w_rd} = w_dout;
  assign rsp_valid = w_pop & w_trk.ld & ~w_disc & ~flush;
  assign rsp_data  = rsp_valid ? DATA_W'(extend(w_trk.size, w_trk.se, 64'(rdata) >> {w_trk.off, 3'b000})) : '0;
  assign rsp_rd    = rsp_valid ? w_rd : '0;
  always_ff @(posedge clk)
    if (resetn && data_ok) assert (w_cnt != '0);
endmodule

// File: tb/tb_dmem_req_issue.sv
// tb_dmem_req_issue: directed scenario tests for dmem_req_issue with hand-computed expectations.
module tb_dmem_req_issue;
  logic        clk = 1'b0, resetn, in_valid, in_ready, in_ld, in_st, in_se, flush;
  logic [1:0]  in_size, size;
  logic [31:0] in_addr, in_wdata, addr, wdata, rdata, rsp_data, exc_badv;
  logic [4:0]  in_rd, rsp_rd;
  logic        req, wr, addr_ok, data_ok, rsp_valid, exc_ale;
  logic [3:0]  wstrb;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  dmem_req_issue #(.DATA_W(32), .ADDR_W(32), .MAX_OUTSTANDING(4), .RD_W(5)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .in_ld(in_ld),
    .in_st(in_st), .in_size(in_size), .in_se(in_se), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_rd(in_rd), .flush(flush), .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_rd(rsp_rd), .exc_ale(exc_ale), .exc_badv(exc_badv)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic ld, input logic [1:0] sz, input logic se,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r);
    in_valid = 1'b1; in_ld = ld; in_st = ~ld; in_size = sz; in_se = se;
    in_addr = a; in_wdata = wd; in_rd = r;
  endtask
  task automatic issue(input logic ld, input logic [1:0] sz, input logic se,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r);
    drive(ld, sz, se, a, wd, r);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL issue_ready got %0b want 1", in_ready); end
    step;
    in_valid = 1'b0; addr_ok = 1'b1;
    #1;
    n_vec++; if (req !== 1'b1 || addr !== a) begin n_err++; $display("FAIL issue_req req=%0b addr=%h want 1/%h", req, addr, a); end
    step;
    addr_ok = 1'b0;
  endtask
  task automatic test_reset;
    resetn = 1'b0; in_valid = 1'b1; in_ld = 1'b1; in_st = 1'b0; in_size = 2'd2; in_se = 1'b0;
    in_addr = 32'h1000; in_wdata = 32'hFFFF_FFFF; in_rd = 5'd3; flush = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
    step; step; step;
    n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL rst_req got %0b want 0", req); end
    n_vec++; if (exc_ale !== 1'b0) begin n_err++; $display("FAIL rst_ale got %0b want 0", exc_ale); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp got %0b want 0", rsp_valid); end
    n_vec++; if ({wstrb, addr, wdata} !== 68'h0) begin n_err++; $display("FAIL rst_bus got %h/%h/%h want 0", wstrb, addr, wdata); end
    in_valid = 1'b0; resetn = 1'b1;
    step;
    n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL rst_idle_req got %0b want 0", req); end
  endtask
  task automatic test_load_word;
    drive(1'b1, 2'd2, 1'b1, 32'h1004, 32'h0, 5'd5);
    step;
    in_valid = 1'b0; addr_ok = 1'b1;
    #1;
    n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL lw_req got %0b want 1", req); end
    n_vec++; if (wr !== 1'b0 || wstrb !== 4'b0000) begin n_err++; $display("FAIL lw_wstrb wr=%0b wstrb=%b want 0/0000", wr, wstrb); end
    n_vec++; if (addr !== 32'h1004 || size !== 2'd2) begin n_err++; $display("FAIL lw_addr got %h/%0d want 1004/2", addr, size); end
    step;
    addr_ok = 1'b0;
    #1;
    n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL lw_req_drop got %0b want 0", req); end
    data_ok = 1'b1; rdata = 32'h8899_AABB;
    #1;
    n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h8899_AABB || rsp_rd !== 5'd5) begin
      n_err++; $display("FAIL lw_rsp got %0b/%h/%0d want 1/8899aabb/5", rsp_valid, rsp_data, rsp_rd); end
    step;
    data_ok = 1'b0;
    #1;
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL lw_rsp_pulse got %0b want 0", rsp_valid); end
  endtask
  task automatic test_load_byte;
    logic [31:0] exp [2];
    exp[0] = 32'hFFFF_FF80; exp[1] = 32'h0000_0080;
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, 2'd0, (i == 0), 32'h1003, 32'h0, 5'd7);
      data_ok = 1'b1; rdata = 32'h80FF_FFFF;
      #1;
      n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== exp[i] || rsp_rd !== 5'd7) begin
        n_err++; $display("FAIL lb_rsp%0d got %0b/%h/%0d want 1/%h/7", i, rsp_valid, rsp_data, rsp_rd, exp[i]); end
      step;
      data_ok = 1'b0;
    end
  endtask
  task automatic test_store_half;
    drive(1'b0, 2'd1, 1'b0, 32'h1002, 32'h0000_1234, 5'd0);
    step;
    in_valid = 1'b0; addr_ok = 1'b1;
    #1;
    n_vec++; if (req !== 1'b1 || wr !== 1'b1) begin n_err++; $display("FAIL sh_req got %0b/%0b want 1/1", req, wr); end
    n_vec++; if (wstrb !== 4'b1100) begin n_err++; $display("FAIL sh_wstrb got %b want 1100", wstrb); end
    n_vec++; if (wdata !== 32'h1234_1234) begin n_err++; $display("FAIL sh_wdata got %h want 12341234", wdata); end
    step;
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
    #1;
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL sh_norsp got %0b want 0", rsp_valid); end
    step;
    data_ok = 1'b0;
  endtask
  task automatic test_ale;
    drive(1'b1, 2'd2, 1'b0, 32'h1001, 32'h0, 5'd9);
    step;
    in_valid = 1'b0; addr_ok = 1'b1;
    #1;
    n_vec++; if (exc_ale !== 1'b1 || exc_badv !== 32'h1001) begin n_err++; $display("FAIL ale_pulse got %0b/%h want 1/1001", exc_ale, exc_badv); end
    n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL ale_noreq got %0b want 0", req); end
    step;
    n_vec++; if (exc_ale !== 1'b0 || req !== 1'b0) begin n_err++; $display("FAIL ale_once got %0b/%0b want 0/0", exc_ale, req); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ale_ready got %0b want 1", in_ready); end
    addr_ok = 1'b0;
  endtask
  task automatic test_back_to_back_full;
    addr_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd2, 1'b0, 32'h2000 + 32'(4 * i), 32'h0, 5'(i + 1));
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d got %0b want 1", i, in_ready); end
      if (i > 0) begin
        n_vec++; if (req !== 1'b1 || addr !== 32'h2000 + 32'(4 * (i - 1))) begin
          n_err++; $display("FAIL b2b_req%0d got %0b/%h want 1/%h", i, req, addr, 32'h2000 + 32'(4 * (i - 1))); end
      end
      step;
    end
    in_valid = 1'b0;
    #1;
    n_vec++; if (req !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL full_block got %0b/%0b want 0/0", req, in_ready); end
    step;
    n_vec++; if (req !== 1'b0 || addr !== 32'h2010) begin n_err++; $display("FAIL full_hold got %0b/%h want 0/2010", req, addr); end
    for (int k = 0; k < 5; k++) begin
      data_ok = 1'b1; rdata = 32'hA000_0000 | 32'(k);
      #1;
      n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== (32'hA000_0000 | 32'(k)) || rsp_rd !== 5'(k + 1)) begin
        n_err++; $display("FAIL order%0d got %0b/%h/%0d want 1/%h/%0d", k, rsp_valid, rsp_data, rsp_rd, 32'hA000_0000 | 32'(k), k + 1); end
      if (k == 0) begin
        n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL pop_noreq got %0b want 0", req); end
      end
      if (k == 1) begin
        n_vec++; if (req !== 1'b1 || addr !== 32'h2010) begin n_err++; $display("FAIL fifth_req got %0b/%h want 1/2010", req, addr); end
      end
      step;
    end
    data_ok = 1'b0; addr_ok = 1'b0;
    #1;
    n_vec++; if (req !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL drain_idle got %0b/%0b want 0/0", req, rsp_valid); end
  endtask
  task automatic test_flush;
    issue(1'b1, 2'd2, 1'b0, 32'h3000, 32'h0, 5'd10);
    issue(1'b1, 2'd2, 1'b0, 32'h3004, 32'h0, 5'd11);
    issue(1'b1, 2'd2, 1'b0, 32'h3008, 32'h0, 5'd12);
    drive(1'b1, 2'd2, 1'b0, 32'h300C, 32'h0, 5'd14);
    step;
    in_valid = 1'b0; flush = 1'b1; addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h1111_1111;
    #1;
    n_vec++; if (rsp_valid !== 1'b0 || req !== 1'b0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_cycle got rsp=%0b req=%0b rdy=%0b want 0/0/0", rsp_valid, req, in_ready); end
    step;
    flush = 1'b0; addr_ok = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rdata = 32'h2222_2222 + 32'(k);
      #1;
      n_vec++; if (rsp_valid !== 1'b0 || req !== 1'b0) begin
        n_err++; $display("FAIL flush_drain%0d got rsp=%0b req=%0b want 0/0", k, rsp_valid, req); end
      step;
    end
    data_ok = 1'b0;
    issue(1'b1, 2'd1, 1'b1, 32'h3012, 32'h0, 5'd13);
    data_ok = 1'b1; rdata = 32'h8765_4321;
    #1;
    n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_8765 || rsp_rd !== 5'd13) begin
      n_err++; $display("FAIL post_flush got %0b/%h/%0d want 1/ffff8765/13", rsp_valid, rsp_data, rsp_rd); end
    step;
    data_ok = 1'b0;
  endtask
  initial begin
    test_reset;
    test_load_word;
    test_load_byte;
    test_store_half;
    test_ale;
    test_back_to_back_full;
    test_flush;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
